adsr_envelope: RTL and testbench

Parametrised, gate-driven ADSR envelope generator; the next generation of our fixed-width, timer-triggered envelope block. Amplitude width and rate-prescaler width are parameters. Each phase has its own programmable rate and a shared step size. The block follows an external `gate` with retrigger and early release. It sits between the note/voice controller, which drives `gate` and the envelope settings, and the amplitude multiplier of one voice.

---
 rtl/adsr_pkg.sv | 14 +
 rtl/adsr_tick_div.sv | 24 ++
 rtl/adsr_envelope.sv | 123 ++++++++++++
 tb/tb_adsr_envelope.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/adsr_pkg.sv
// Shared phase encoding for the ADSR envelope generator.
package adsr_pkg;

   localparam int PHASE_W = 3;

   typedef enum logic [PHASE_W-1:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } phase_t;

endpackage

// File: rtl/adsr_tick_div.sv
// Per-phase rate divider: one tick every div+1 enabled clocks.
module adsr_tick_div #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] div,
   input  logic             clear,
   input  logic             enable,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;

   assign tick = enable & (cnt == div);

   always_ff @(posedge clk) begin
      if (rst || clear || !enable || tick)
         cnt <= '0;
      else
         cnt <= cnt + {{(DIV_W-1){1'b0}}, 1'b1};
   end

endmodule

// File: rtl/adsr_envelope.sv
// Gate-driven ADSR envelope with legato retrigger and saturating steps.
module adsr_envelope #(
   parameter int WIDTH = 8,
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             gate,
   input  logic [WIDTH-1:0] peak,
   input  logic [WIDTH-1:0] sustain,
   input  logic [WIDTH-1:0] step,
   input  logic [DIV_W-1:0] attack_div,
   input  logic [DIV_W-1:0] decay_div,
   input  logic [DIV_W-1:0] release_div,
   output logic [WIDTH-1:0] amplitude,
   output logic [2:0]       phase,
   output logic             active,
   output logic             done
);

   import adsr_pkg::*;

   phase_t           ph_q;
   logic [WIDTH-1:0] amp_q;
   logic             gate_q;
   logic             rise;
   logic             gate_off;
   logic             run;
   logic             tick;
   logic [WIDTH-1:0] stp;
   logic [WIDTH-1:0] sus_eff;
   logic [WIDTH:0]   sum_up;
   logic [WIDTH:0]   sus_up;
   logic [DIV_W-1:0] div_sel;

   assign rise     = gate & ~gate_q;
   assign gate_off = ~gate & ((ph_q == ATTACK) |
                              (ph_q == DECAY)  |
                              (ph_q == SUSTAIN));
   assign run      = (ph_q == ATTACK) |
                     (ph_q == DECAY)  |
                     (ph_q == RELEASE);

   assign stp     = (step == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : step;
   assign sus_eff = (sustain < peak) ? sustain : peak;
   // One extra bit so the threshold tests never wrap.
   assign sum_up  = {1'b0, amp_q} + {1'b0, stp};
   assign sus_up  = {1'b0, sus_eff} + {1'b0, stp};

   always_comb begin
      div_sel = '0;
      case (ph_q)
         ATTACK:  div_sel = attack_div;
         DECAY:   div_sel = decay_div;
         RELEASE: div_sel = release_div;
         default: div_sel = '0;
      endcase
   end

   adsr_tick_div #(
      .DIV_W(DIV_W)
   ) u_div (
      .clk   (clk),
      .rst   (rst),
      .div   (div_sel),
      .clear (rise | gate_off),
      .enable(run),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ph_q   <= IDLE;
         amp_q  <= '0;
         gate_q <= 1'b0;
         done   <= 1'b0;
      end else begin
         gate_q <= gate;
         done   <= 1'b0;
         if (rise) begin
            ph_q <= ATTACK;
         end else if (gate_off) begin
            ph_q <= RELEASE;
         end else begin
            case (ph_q)
               IDLE: ;
               ATTACK: if (tick) begin
                  if (sum_up >= {1'b0, peak}) begin
                     amp_q <= peak;
                     ph_q  <= DECAY;
                  end else begin
                     amp_q <= sum_up[WIDTH-1:0];
                  end
               end
               DECAY: if (tick) begin
                  if ({1'b0, amp_q} <= sus_up) begin
                     amp_q <= sus_eff;
                     ph_q  <= SUSTAIN;
                  end else begin
                     amp_q <= amp_q - stp;
                  end
               end
               SUSTAIN: amp_q <= sus_eff;
               RELEASE: if (tick) begin
                  if (amp_q <= stp) begin
                     amp_q <= '0;
                     ph_q  <= IDLE;
                     done  <= 1'b1;
                  end else begin
                     amp_q <= amp_q - stp;
                  end
               end
               default: ph_q <= IDLE;
            endcase
         end
      end
   end

   assign amplitude = amp_q;
   assign phase     = ph_q;
   assign active    = (ph_q != IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed checks of the ADSR envelope with hand-computed expectations.
module tb_adsr_envelope;

   logic       clk = 1'b0;
   logic       rst;
   logic       gate;
   logic [7:0] peak, sustain, step;
   logic [7:0] attack_div, decay_div, release_div;
   logic [7:0] amplitude;
   logic [2:0] phase;
   logic       active, done;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   adsr_envelope #(
      .WIDTH(8),
      .DIV_W(8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .gate       (gate),
      .peak       (peak),
      .sustain    (sustain),
      .step       (step),
      .attack_div (attack_div),
      .decay_div  (decay_div),
      .release_div(release_div),
      .amplitude  (amplitude),
      .phase      (phase),
      .active     (active),
      .done       (done)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic st(input string tag, input int a, input int p,
                     input int d);
      chk({tag, ".amp"}, amplitude, a);
      chk({tag, ".phase"}, phase, p);
      chk({tag, ".active"}, active, (p != 0) ? 1 : 0);
      chk({tag, ".done"}, done, d);
   endtask

   initial begin
      rst = 1'b1; gate = 1'b0;
      peak = 8'd100; sustain = 8'd60; step = 8'd1;
      attack_div = 0; decay_div = 0; release_div = 0;
      clks(2);
      st("reset", 0, 0, 0);
      rst = 1'b0;
      clks(1);

      // full envelope
      gate = 1'b1;
      clks(1);   st("full.att0", 0, 1, 0);
      clks(99);  st("full.att99", 99, 1, 0);
      clks(1);   st("full.peak", 100, 2, 0);
      clks(39);  st("full.dec39", 61, 2, 0);
      clks(1);   st("full.sus", 60, 3, 0);
      clks(10);  st("full.hold", 60, 3, 0);
      gate = 1'b0;
      clks(1);   st("full.rel0", 60, 4, 0);
      clks(59);  st("full.rel59", 1, 4, 0);
      clks(1);   st("full.idle", 0, 0, 1);
      clks(1);   st("full.done1", 0, 0, 0);

      // saturation, attack tick every 4 clocks
      peak = 8'd255; sustain = 8'd255; step = 8'd200;
      attack_div = 8'd3;
      gate = 1'b1;
      clks(1);   st("sat.att0", 0, 1, 0);
      clks(3);   st("sat.wait", 0, 1, 0);
      clks(1);   st("sat.t1", 200, 1, 0);
      clks(3);   st("sat.wait2", 200, 1, 0);
      clks(1);   st("sat.t2", 255, 2, 0);
      clks(1);   st("sat.sus", 255, 3, 0);
      gate = 1'b0;
      clks(1);   st("sat.rel", 255, 4, 0);
      clks(1);   st("sat.r1", 55, 4, 0);
      clks(1);   st("sat.r2", 0, 0, 1);

      // early release and retrigger from release
      peak = 8'd100; sustain = 8'd50; step = 8'd10;
      attack_div = 0;
      gate = 1'b1;
      clks(1);   st("early.att", 0, 1, 0);
      clks(4);   st("early.40", 40, 1, 0);
      gate = 1'b0;
      clks(1);   st("early.rel", 40, 4, 0);
      step = 8'd5;
      clks(3);   st("early.r25", 25, 4, 0);
      gate = 1'b1;
      clks(1);   st("early.retrig", 25, 1, 0);
      clks(1);   st("early.up", 30, 1, 0);
      gate = 1'b0;
      clks(1);   st("early.rel2", 30, 4, 0);
      clks(5);   st("early.r5", 5, 4, 0);
      clks(1);   st("early.idle", 0, 0, 1);

      // sustain above peak, live sustain change
      peak = 8'd150; sustain = 8'd200; step = 8'd50;
      gate = 1'b1;
      clks(1);   st("sus.att", 0, 1, 0);
      clks(3);   st("sus.peak", 150, 2, 0);
      clks(1);   st("sus.eff", 150, 3, 0);
      sustain = 8'd90;
      clks(1);   st("sus.live", 90, 3, 0);
      gate = 1'b0;
      clks(1);   st("sus.rel", 90, 4, 0);
      clks(1);   st("sus.r1", 40, 4, 0);
      clks(1);   st("sus.idle", 0, 0, 1);

      // step 0 acts as 1; reset mid-decay with gate held high
      peak = 8'd3; sustain = 8'd1; step = 8'd0;
      gate = 1'b1;
      clks(1);   st("s0.att", 0, 1, 0);
      clks(1);   st("s0.a1", 1, 1, 0);
      clks(2);   st("s0.peak", 3, 2, 0);
      clks(1);   st("s0.dec", 2, 2, 0);
      rst = 1'b1;
      clks(1);   st("rst.mid", 0, 0, 0);
      clks(1);   st("rst.hold", 0, 0, 0);
      rst = 1'b0;
      clks(1);   st("rst.rise", 0, 1, 0);
      clks(1);   st("rst.a1", 1, 1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
